// File: rtl/demux1to8_5bit_seq.sv
// Sequential 1-to-8 distributor for 5-bit beats into eight held slot registers.
// Latency: an accepted beat is visible on its OutN the cycle after acceptance.
// Backpressure: InReady is low in DONE, during Clear, and in IDLE with AutoMode=1.
// Optional overwrite protection in manual mode: define DEMUX_OVERWRITE_PROTECT_EN.
module demux1to8_5bit_seq #(
  parameter int WIDTH = 5,
  parameter int SLOTS = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic [2:0]       Sel,
  input  logic             InValid,
  output logic             InReady,
  input  logic             AutoMode,
  input  logic             Start,
  input  logic             Clear,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic [WIDTH-1:0] Out5,
  output logic [WIDTH-1:0] Out6,
  output logic [WIDTH-1:0] Out7,
  output logic [SLOTS-1:0] OutValid,
  output logic [2:0]       Idx,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SLOTS-1:0] vld_q, vld_d;
  logic [2:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] slot_q [SLOTS];

  // Slot write port: at most one slot is written per cycle.
  logic             wr_en;
  logic [2:0]       wr_idx;
  logic             accept;

`ifdef DEMUX_OVERWRITE_PROTECT_EN
  logic             err_q, err_d;
`endif

  // Ready depends only on state and the mode/clear inputs, never on InValid.
  always_comb begin
    InReady = 1'b0;
    case (state_q)
      ST_IDLE: InReady = ~AutoMode & ~Clear;
      ST_FILL: InReady = ~Clear;
      default: InReady = 1'b0;
    endcase
  end

  assign accept = InValid & InReady;

  // Next-state, slot-write selection and control register updates.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = Sel;
`ifdef DEMUX_OVERWRITE_PROTECT_EN
    err_d   = err_q;
`endif
    if (Clear) begin
      // Clear wins over Start and beats; slot data is deliberately kept.
      state_d = ST_IDLE;
      vld_d   = '0;
      idx_d   = 3'd0;
`ifdef DEMUX_OVERWRITE_PROTECT_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (AutoMode && Start) begin
            // InReady is low here, so no beat can be lost on the Start cycle.
            state_d = ST_FILL;
            idx_d   = 3'd0;
            vld_d   = '0;
          end else if (accept) begin
`ifdef DEMUX_OVERWRITE_PROTECT_EN
            // Occupied slot: consume the beat, keep the old data, flag it.
            if (vld_q[Sel]) begin
              err_d = 1'b1;
            end else begin
              wr_en      = 1'b1;
              vld_d[Sel] = 1'b1;
            end
`else
            wr_en      = 1'b1;
            vld_d[Sel] = 1'b1;
`endif
          end
        end
        ST_FILL: begin
          if (accept) begin
            wr_en        = 1'b1;
            wr_idx       = idx_q;
            vld_d[idx_q] = 1'b1;
            idx_d        = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      vld_q   <= '0;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Held slot data; only the addressed slot changes on a write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < SLOTS; k++) begin
        slot_q[k] <= '0;
      end
    end else if (wr_en) begin
      slot_q[wr_idx] <= In;
    end
  end

`ifdef DEMUX_OVERWRITE_PROTECT_EN
  // Sticky overwrite flag, cleared only by Clear or Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign Out0     = slot_q[0];
  assign Out1     = slot_q[1];
  assign Out2     = slot_q[2];
  assign Out3     = slot_q[3];
  assign Out4     = slot_q[4];
  assign Out5     = slot_q[5];
  assign Out6     = slot_q[6];
  assign Out7     = slot_q[7];
  assign OutValid = vld_q;
  assign Idx      = idx_q;
  assign Busy     = (state_q == ST_FILL);
  assign Done     = done_q;

endmodule

// File: doc/demux1to8_5bit_seq.md
Name: demux1to8_5bit_seq

Overview:
- Sequential 1-to-8 distributor for 5-bit values; the write-side counterpart of the multiplier's 8-to-1 5-bit selector.
- Accepts a stream of 5-bit beats over a valid/ready handshake and latches each beat into one of eight held output registers.
- Slot is chosen either by an explicit select (manual mode) or by an internal auto-incrementing index (burst fill mode).
- Feeds the operand and shift-amount slots that the multiplier datapath later selects from.

Parameters:
- WIDTH, 5, data width of each beat and each output slot.
- SLOTS, 8, number of output slots; fixed at 8, and the select/index are 3 bits.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- In  input  WIDTH  data beat.
- Sel  input  3  target slot in manual mode; ignored in auto mode.
- InValid  input  1  beat present on In.
- InReady  output  1  block accepts a beat this cycle; a beat is accepted when InValid and InReady are both high.
- AutoMode  input  1  0 = manual, 1 = burst fill.
- Start  input  1  single-cycle pulse that begins a burst (effective only in IDLE with AutoMode=1).
- Clear  input  1  synchronous clear of all slot-valid bits, returns to IDLE.
- Out0..Out7  output  WIDTH each  held slot registers.
- OutValid  output  8  bit k set when slot k holds written data.
- Idx  output  3  current burst index.
- Busy  output  1  high in FILL.
- Done  output  1  high for exactly one cycle after the last burst beat.
- Err  output  1  sticky overwrite error (see Optional Feature).

Behaviour:
- Reset (async, active-high): state=IDLE; Out0..Out7=0; OutValid=0; Idx=0; Busy=0; Done=0; Err=0.
- States: IDLE, FILL, DONE.
- InReady (combinational):
  - IDLE: InReady = ~AutoMode & ~Clear.
  - FILL: InReady = ~Clear.
  - DONE: InReady = 0.
- IDLE, manual mode: an accepted beat writes In into slot Sel and sets OutValid[Sel] on the same clock edge. Write latency is 1 cycle: data is visible on OutN the cycle after acceptance. Back-to-back beats are allowed every cycle. Rewriting a slot overwrites it; OutValid stays 1.
- IDLE, Start & AutoMode & ~Clear: go to FILL, Idx<=0, OutValid<=0. No beat is accepted that cycle, because InReady=0 when AutoMode=1.
- FILL:
  - Each accepted beat writes slot Idx, sets OutValid[Idx], then Idx<=Idx+1.
  - A beat accepted with Idx=7 moves to DONE; Idx wraps to 0.
  - Cycles with InValid low hold all state.
  - Start in FILL is ignored.
  - Changing AutoMode mid-burst is ignored until the block returns to IDLE.
- DONE: Done=1 for one cycle, then unconditionally IDLE. OutValid=8'hFF is retained.
- Busy = (state==FILL).
- Clear (sync) has priority over Start and beats: OutValid<=0, Idx<=0, state<=IDLE, Done<=0. Slot data is retained; only the valid bits clear. Err is also cleared by Clear.
- Reset asserted mid-burst: immediate return to reset values; the partial burst is discarded.
- Sel and Idx are always in range (3-bit), so there are no out-of-range cases.

Optional Feature:
- Macro: DEMUX_OVERWRITE_PROTECT_EN.
- Defined:
  - In manual mode, an accepted beat targeting a slot whose OutValid bit is already 1 is consumed (the handshake completes) but not written.
  - Err is set and stays 1 until Clear or Reset.
  - Burst mode is unaffected, since a burst clears OutValid at Start.
- Undefined: overwrites proceed normally and Err is tied to 0.

Test Plan:
- Reset mid-operation: assert Reset during FILL at Idx=4 -> all outputs 0 immediately, state IDLE, InReady=1 (given AutoMode=0).
- Manual writes: AutoMode=0; beats (Sel=3, In=5'h15), then (Sel=0, In=5'h0A) on consecutive cycles -> Out3=5'h15 and Out0=5'h0A one cycle after each acceptance; OutValid=8'b0000_1001; other slots stay 0.
- Burst with stalls: AutoMode=1, Start pulse, then beats 1..8 with InValid dropped for 2 cycles after beat 4 -> OutK=K+1; Idx holds at 4 during the stall; Busy high throughout FILL; Done is a single-cycle pulse the cycle after beat 8; OutValid=8'hFF; InReady=0 in DONE.
- Start collision: AutoMode=1, Start and InValid asserted together in IDLE -> no write, InReady=0, state FILL; the next beat lands in Out0.
- Clear priority: Clear asserted together with an accepted-looking beat in FILL at Idx=5 -> no write, OutValid=0, Idx=0, state IDLE, previous slot data unchanged.
- Macro on: manual write Sel=2, In=5'h07, then Sel=2, In=5'h1F -> Out2 stays 5'h07, Err=1 until Clear. Macro off: same stimulus -> Out2=5'h1F, Err=0.
